// File: rtl/add_pipelined.sv
// Pipelined N-bit adder/subtractor: carry chain split into STAGES registered segments,
// valid/ready stream interface with a global stall.
module add_pipelined #(
   parameter int unsigned N      = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow,
   output logic         zero
);
   localparam int unsigned SEG = (STAGES == 0) ? 1 : N / STAGES;

   if (STAGES < 1 || STAGES > N || (N % SEG) != 0 || SEG * STAGES != N) begin : g_bad_params
      $error("add_pipelined: STAGES must satisfy 1 <= STAGES <= N and N %% STAGES == 0");
   end

   logic         advance;
   logic [N-1:0] b_eff;
   logic         cin_eff;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;
   assign b_eff    = sub ? ~b : b;
   assign cin_eff  = c_in ^ sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be summed on entry to this stage; lower segments are dropped.
      localparam int unsigned REM = N - k * SEG;

      logic [REM-1:0] a_i;
      logic [REM-1:0] b_i;
      logic [N-1:0]   s_i;
      logic           c_i;
      logic           v_i;
      logic [SEG:0]   seg_sum;
      logic [N-1:0]   s_n;
      logic           v_q;
      logic           c_q;
      logic [N-1:0]   s_q;

      if (k == 0) begin : g_src
         assign a_i = a;
         assign b_i = b_eff;
         assign s_i = '0;
         assign c_i = cin_eff;
         assign v_i = in_valid;
      end else begin : g_src
         assign a_i = g_stage[k-1].g_fwd.a_q;
         assign b_i = g_stage[k-1].g_fwd.b_q;
         assign s_i = g_stage[k-1].s_q;
         assign c_i = g_stage[k-1].c_q;
         assign v_i = g_stage[k-1].v_q;
      end

      always_comb begin
         seg_sum = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};
         s_n = s_i;
         s_n[k*SEG +: SEG] = seg_sum[SEG-1:0];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_i;
            c_q <= seg_sum[SEG];
            s_q <= s_n;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [REM-SEG-1:0] a_q;
         logic [REM-SEG-1:0] b_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_i[REM-1:SEG];
               b_q <= b_i[REM-1:SEG];
            end
         end
      end else begin : g_fin
         logic ov_q;
         logic z_q;

         // Flags are resolved in the last stage, where the operand MSBs and full sum meet.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ov_q <= 1'b0;
               z_q  <= 1'b0;
            end else if (advance) begin
               ov_q <= (a_i[REM-1] == b_i[REM-1]) && (s_n[N-1] != a_i[REM-1]);
               z_q  <= (s_n == '0);
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign c_out     = g_stage[STAGES-1].c_q;
   assign overflow  = g_stage[STAGES-1].g_fin.ov_q;
   assign zero      = g_stage[STAGES-1].g_fin.z_q;

endmodule

// File: tb/tb_add_pipelined.sv
// Bench for add_pipelined: three instances (STAGES = 4, 1, 32) checked against an
// arithmetic reference model.
module tb_add_pipelined;
   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        c_in;
   logic        sub;
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [31:0] sum       [3];
   logic        c_out     [3];
   logic        overflow  [3];
   logic        zero      [3];

   int n_cmp;
   int n_bad;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned S = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
      add_pipelined #(.N(32), .STAGES(S)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a         (a),
         .b         (b),
         .c_in      (c_in),
         .sub       (sub),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .sum       (sum[g]),
         .c_out     (c_out[g]),
         .overflow  (overflow[g]),
         .zero      (zero[g])
      );
   end

   always #5 clk = ~clk;

   function automatic int stg(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
   endfunction

   // Reference: plain integer arithmetic; returns {zero, overflow, c_out, sum}.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
      longint      ur;
      longint      sr;
      logic [31:0] s;
      logic        co;
      logic        ov;
      if (sb) begin
         ur = longint'(x) - longint'(y) - longint'(ci);
         co = (ur >= 0);
         sr = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
      end else begin
         ur = longint'(x) + longint'(y) + longint'(ci);
         co = (ur > 64'sh0_FFFF_FFFF);
         sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      end
      s  = ur[31:0];
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {(s == 32'd0), ov, co, s};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (out_valid[d] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid[d]);
         end
         n_cmp++;
         if ({zero[d], overflow[d], c_out[d], sum[d]} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outputs dut%0d: got %h want 0", d,
                     {zero[d], overflow[d], c_out[d], sum[d]});
         end
      end
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (in_ready[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]);
         end
      end
   endtask

   task automatic test_directed(input int d, input logic [31:0] x, input logic [31:0] y,
                                input logic ci, input logic sb, input string nm);
      logic [34:0] e;
      int          lat;
      bit          got;
      e = model(x, y, ci, sb);
      @(negedge clk);
      a = x; b = y; c_in = ci; sub = sb;
      in_valid[d]  = 1'b1;
      out_ready[d] = 1'b1;
      #1;
      n_cmp++;
      if (in_ready[d] !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_in_ready dut%0d: got %b want 1", nm, d, in_ready[d]);
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 80) begin
         @(posedge clk);
         #1;
         lat++;
         in_valid[d] = 1'b0;
         if (out_valid[d] === 1'b1) got = 1'b1;
      end
      n_cmp++;
      if (!got || lat != stg(d)) begin
         n_bad++;
         $display("FAIL %s_latency dut%0d: got %0d (seen=%0b) want %0d", nm, d, lat, got, stg(d));
      end
      n_cmp++;
      if (sum[d] !== e[31:0]) begin
         n_bad++;
         $display("FAIL %s_sum dut%0d: got %h want %h", nm, d, sum[d], e[31:0]);
      end
      n_cmp++;
      if (c_out[d] !== e[32]) begin
         n_bad++;
         $display("FAIL %s_c_out dut%0d: got %b want %b", nm, d, c_out[d], e[32]);
      end
      n_cmp++;
      if (overflow[d] !== e[33]) begin
         n_bad++;
         $display("FAIL %s_overflow dut%0d: got %b want %b", nm, d, overflow[d], e[33]);
      end
      n_cmp++;
      if (zero[d] !== e[34]) begin
         n_bad++;
         $display("FAIL %s_zero dut%0d: got %b want %b", nm, d, zero[d], e[34]);
      end
      @(negedge clk);
   endtask

   task automatic test_stream();
      logic [34:0] q[$];
      logic [34:0] e;
      int          sent;
      int          seen;
      sent = 0;
      seen = 0;
      out_ready[0] = 1'b1;
      for (int cyc = 0; cyc < 107; cyc++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
         c_in = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         in_valid[0] = (sent < 100);
         #1;
         n_cmp++;
         if (in_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_in_ready cyc%0d: got %b want 1", cyc, in_ready[0]);
         end
         n_cmp++;
         if (out_valid[0] !== ((cyc >= 4 && cyc < 104) ? 1'b1 : 1'b0)) begin
            n_bad++;
            $display("FAIL stream_cadence cyc%0d: got out_valid=%b want %b", cyc, out_valid[0],
                     (cyc >= 4 && cyc < 104));
         end
         if (out_valid[0] === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL stream_spurious cyc%0d: got result %h want none", cyc, sum[0]);
            end else begin
               e = q.pop_front();
               seen++;
               if ({zero[0], overflow[0], c_out[0], sum[0]} !== e) begin
                  n_bad++;
                  $display("FAIL stream_result cyc%0d: got %h want %h", cyc,
                           {zero[0], overflow[0], c_out[0], sum[0]}, e);
               end
            end
         end
         if (in_valid[0] && in_ready[0]) begin
            q.push_back(model(a, b, c_in, sub));
            sent++;
         end
      end
      in_valid[0] = 1'b0;
      n_cmp++;
      if (seen != 100 || q.size() != 0) begin
         n_bad++;
         $display("FAIL stream_count: got %0d results (%0d pending) want 100 (0)", seen, q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [34:0] q[$];
      logic [34:0] e;
      logic [34:0] cur;
      logic [34:0] prev_out;
      bit          prev_stall;
      int          acc;
      int          pops;
      acc = 0;
      pops = 0;
      prev_stall = 1'b0;
      prev_out = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         a = $urandom; b = $urandom;
         c_in = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         in_valid[0]  = (cyc < 500) ? ($urandom_range(0, 99) < 70) : 1'b0;
         out_ready[0] = (cyc < 500) ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         cur = {zero[0], overflow[0], c_out[0], sum[0]};
         if (prev_stall) begin
            n_cmp++;
            if (out_valid[0] !== 1'b1 || cur !== prev_out) begin
               n_bad++;
               $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 %h", cyc, out_valid[0], cur, prev_out);
            end
         end
         if (out_valid[0] === 1'b1 && out_ready[0] === 1'b0) begin
            n_cmp++;
            if (in_ready[0] !== 1'b0) begin
               n_bad++;
               $display("FAIL bp_in_ready cyc%0d: got %b want 0", cyc, in_ready[0]);
            end
         end
         if (out_valid[0] === 1'b1 && out_ready[0] === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL bp_spurious cyc%0d: got result %h want none", cyc, cur);
            end else begin
               e = q.pop_front();
               pops++;
               if (cur !== e) begin
                  n_bad++;
                  $display("FAIL bp_result cyc%0d: got %h want %h", cyc, cur, e);
               end
            end
         end
         if (in_valid[0] && in_ready[0] === 1'b1) begin
            q.push_back(model(a, b, c_in, sub));
            acc++;
         end
         prev_stall = (out_valid[0] === 1'b1) && !out_ready[0];
         prev_out = cur;
      end
      in_valid[0] = 1'b0;
      n_cmp++;
      if (pops != acc || q.size() != 0) begin
         n_bad++;
         $display("FAIL bp_count: got %0d results (%0d pending) want %0d (0)", pops, q.size(), acc);
      end
   endtask

   task automatic test_reset_inflight();
      bit leak;
      out_ready[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 32'h100 * (i + 1); b = 32'h11; c_in = 1'b0; sub = 1'b0;
         in_valid[0] = 1'b1;
      end
      @(negedge clk);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid[0] !== 1'b1 || sum[0] !== 32'h111) begin
         n_bad++;
         $display("FAIL rst_pre_valid: got v=%b sum=%h want v=1 sum=00000111", out_valid[0], sum[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_async_valid: got %b want 0", out_valid[0]);
      end
      n_cmp++;
      if ({zero[0], overflow[0], c_out[0], sum[0]} !== 35'd0) begin
         n_bad++;
         $display("FAIL rst_async_outputs: got %h want 0", {zero[0], overflow[0], c_out[0], sum[0]});
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready[0] = 1'b1;
      leak = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid[0] !== 1'b0) leak = 1'b1;
      end
      n_cmp++;
      if (leak) begin
         n_bad++;
         $display("FAIL rst_discard: got out_valid=1 after reset want 0");
      end
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b1;
      end
      n_cmp = 0;
      n_bad = 0;

      test_reset();
      for (int d = 0; d < 3; d++) begin
         test_directed(d, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, "basic");
         test_directed(d, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "carry_all");
         test_directed(d, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ovf");
         test_directed(d, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, "sub_borrow");
         test_directed(d, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, "sub_bin");
         test_directed(d, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
      end
      test_stream();
      test_backpressure();
      test_reset_inflight();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
